// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester burst arbiter in front of one single-port
// row-wide SRAM (1-cycle read latency). Grants whole bursts and alternates
// priority on ties.
module sram_port_arbiter #(
  parameter int unsigned ARR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [1:0]                          req,
  input  logic [1:0]                          wr,
  input  logic [1:0][6:0]                     addr,
  input  logic [1:0][7:0]                     len,
  input  logic [1:0][ARR_WIDTH-1:0][7:0]      wdata,
  output logic [1:0]                          gnt,
  output logic [1:0]                          beat,
  output logic [1:0]                          rvalid,
  output logic [1:0]                          done,
  output logic [ARR_WIDTH-1:0][7:0]           rdata,
  output logic [6:0]                          sram_addr,
  output logic                                sram_wr_en,
  output logic [ARR_WIDTH-1:0][7:0]           sram_in_data,
  input  logic [ARR_WIDTH-1:0][7:0]           sram_out_data
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ptr;
  logic                r_sel;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_rem;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [1:0]          r_rvalid;

  logic                w_pick;
  logic                w_issue;
  logic [1:0]          w_beat;

  function automatic logic [1:0] onehot(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  // Tie goes to the round-robin pointer, otherwise the sole requester.
  assign w_pick  = (req == 2'b11) ? r_ptr : req[1];

  // A row is issued to the SRAM in every advancing BURST cycle.
  assign w_issue = (r_state == S_BURST) && enable;
  assign w_beat  = w_issue ? onehot(r_sel) : 2'b00;

  assign beat         = w_beat;
  assign gnt          = r_gnt;
  assign done         = r_done;
  assign rvalid       = r_rvalid;
  assign rdata        = sram_out_data;
  assign sram_addr    = w_issue ? r_addr : '0;
  assign sram_wr_en   = w_issue && r_wr;
  assign sram_in_data = (w_issue && r_wr) ? wdata[r_sel] : '0;

  // Burst FSM, address/count tracking and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_sel    <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_rvalid <= 2'b00;
    end else begin
      // SRAM data returns one cycle after a read beat, even across a stall.
      r_rvalid <= (w_issue && !r_wr) ? w_beat : 2'b00;
      if (enable) begin
        case (r_state)
          S_IDLE: begin
            if (req != 2'b00) begin
              r_sel   <= w_pick;
              r_wr    <= wr[w_pick];
              r_addr  <= addr[w_pick];
              r_rem   <= (len[w_pick] == 8'd0) ? 8'd128 : len[w_pick];
              r_gnt   <= onehot(w_pick);
              r_state <= S_BURST;
            end
          end
          S_BURST: begin
            r_addr <= r_addr + 7'd1;
            r_rem  <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_gnt   <= 2'b00;
              r_done  <= onehot(r_sel);
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            r_done  <= 2'b00;
            r_ptr   <= ~r_sel;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM environment model, burst-level reference
// model with per-cycle comparison, directed scenarios and random traffic.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned RW = AW * 8;

  logic                       clk;
  logic                       rst_n;
  logic                       enable;
  logic [1:0]                 req;
  logic [1:0]                 wr;
  logic [1:0][6:0]            addr;
  logic [1:0][7:0]            len;
  logic [1:0][AW-1:0][7:0]    wdata;
  logic [1:0]                 gnt;
  logic [1:0]                 beat;
  logic [1:0]                 rvalid;
  logic [1:0]                 done;
  logic [AW-1:0][7:0]         rdata;
  logic [6:0]                 sram_addr;
  logic                       sram_wr_en;
  logic [AW-1:0][7:0]         sram_in_data;
  logic [AW-1:0][7:0]         sram_out_data;

  int n_checks;
  int n_fail;
  bit check_en;

  sram_port_arbiter #(.ARR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .wr(wr),
    .addr(addr), .len(len), .wdata(wdata), .gnt(gnt), .beat(beat),
    .rvalid(rvalid), .done(done), .rdata(rdata), .sram_addr(sram_addr),
    .sram_wr_en(sram_wr_en), .sram_in_data(sram_in_data),
    .sram_out_data(sram_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with one-cycle read latency.
  logic [AW-1:0][7:0] s_mem [128];
  always @(posedge clk) begin
    if (sram_wr_en) s_mem[sram_addr] <= sram_in_data;
    sram_out_data <= s_mem[sram_addr];
  end

  // Reference model: a burst is {who, dir, start, n}; k rows issued so far.
  int             m_phase;   // 0 waiting, 1 issuing rows, 2 wrap-up cycle
  int             m_who;
  bit             m_wr;
  int             m_start;
  int             m_n;
  int             m_k;
  int             m_ptr;
  logic [1:0]     m_rv;
  logic [RW-1:0]  m_rdata;
  logic [RW-1:0]  m_mem [128];

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int i = 0; i < int'(RW / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the reference model on each clock edge.
  always @(posedge clk) begin : model
    bit iss;
    int a;
    iss = (m_phase == 1) && enable;
    a   = (m_start + m_k) % 128;
    if (iss && m_wr) m_mem[a] = wdata[m_who];
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_k     = 0;
      m_rv    = 2'b00;
    end else begin
      m_rv = (iss && !m_wr) ? oh(m_who) : 2'b00;
      if (iss && !m_wr) m_rdata = m_mem[a];
      if (enable) begin
        if (m_phase == 0) begin
          if (req != 2'b00) begin
            m_who   = (req == 2'b11) ? m_ptr : ((req == 2'b10) ? 1 : 0);
            m_wr    = wr[m_who];
            m_start = int'(addr[m_who]);
            m_n     = (len[m_who] == 8'd0) ? 128 : int'(len[m_who]);
            m_k     = 0;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_k++;
          if (m_k == m_n) m_phase = 2;
        end else begin
          m_ptr   = 1 - m_who;
          m_phase = 0;
        end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin : compare
    bit iss;
    int a;
    iss = (m_phase == 1) && enable;
    a   = (m_start + m_k) % 128;
    if (check_en) begin
      chk("gnt", RW'(gnt), RW'((m_phase == 1) ? oh(m_who) : 2'b00));
      chk("beat", RW'(beat), RW'(iss ? oh(m_who) : 2'b00));
      chk("sram_addr", RW'(sram_addr), iss ? RW'(a) : '0);
      chk("sram_wr_en", RW'(sram_wr_en), RW'(iss && m_wr));
      chk("sram_in_data", RW'(sram_in_data), (iss && m_wr) ? RW'(wdata[m_who]) : '0);
      chk("done", RW'(done), RW'((m_phase == 2) ? oh(m_who) : 2'b00));
      chk("rvalid", RW'(rvalid), RW'(m_rv));
      if (m_rv != 2'b00) chk("rdata", RW'(rdata), m_rdata);
    end
  end

  initial begin : stim
    int            nb;
    int            done_cyc;
    int            nr;
    int            a1 [4];
    int            rv_cyc [3];
    logic [RW-1:0] rd [3];
    logic [RW-1:0] exp_rd [3];
    logic [RW-1:0] snap;
    logic [1:0]    g3 [9];
    logic [1:0]    exp3 [9];
    int            exp_a1 [4];
    int            exp_rv [3];

    n_checks = 0; n_fail = 0; check_en = 1'b0;
    rst_n = 1'b0; enable = 1'b1; req = 2'b00; wr = 2'b00;
    addr = '0; len = '0; wdata = '0;
    m_phase = 0; m_who = 0; m_wr = 1'b0; m_start = 0; m_n = 0; m_k = 0;
    m_ptr = 0; m_rv = 2'b00; m_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      snap = rnd_row();
      s_mem[i] = snap;
      m_mem[i] = snap;
    end

    tick();
    check_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("reset_gnt", RW'(gnt), '0);
    chk("reset_done", RW'(done), '0);
    chk("reset_rvalid", RW'(rvalid), '0);
    chk("reset_beat", RW'(beat), '0);

    // Write burst wrapping past row 127.
    req = 2'b01; wr = 2'b01; addr[0] = 7'd126; len[0] = 8'd4; wdata[0] = rnd_row();
    nb = 0; done_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = 2'b00; wdata[0] = rnd_row();
      #1;
      if (beat[0]) begin
        if (nb < 4) a1[nb] = int'(sram_addr);
        nb++;
        chk("t1_wr_en", RW'(sram_wr_en), RW'(1'b1));
      end
      if (done[0] && done_cyc == 0) done_cyc = c;
    end
    exp_a1 = '{126, 127, 0, 1};
    chk("t1_nbeats", RW'(nb), RW'(4));
    for (int i = 0; i < 4; i++) chk("t1_addr", RW'(a1[i]), RW'(exp_a1[i]));
    chk("t1_done_cycle", RW'(done_cyc), RW'(5));

    // Read burst from requester 1.
    exp_rd[0] = m_mem[5]; exp_rd[1] = m_mem[6]; exp_rd[2] = m_mem[7];
    req = 2'b10; wr = 2'b00; addr[1] = 7'd5; len[1] = 8'd3;
    nr = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req = 2'b00;
      #1;
      if (rvalid[1]) begin
        if (nr < 3) begin
          rv_cyc[nr] = c;
          rd[nr] = rdata;
        end
        nr++;
      end
    end
    exp_rv = '{2, 3, 4};
    chk("t2_nrvalid", RW'(nr), RW'(3));
    for (int i = 0; i < 3; i++) begin
      chk("t2_rv_cycle", RW'(rv_cyc[i]), RW'(exp_rv[i]));
      chk("t2_rdata", rd[i], exp_rd[i]);
    end

    // Tie after reset with both requests held high.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11; wr = 2'b11; addr[0] = 7'd20; addr[1] = 7'd30;
    len[0] = 8'd2; len[1] = 8'd2;
    wdata[0] = rnd_row(); wdata[1] = rnd_row();
    for (int c = 1; c <= 9; c++) begin
      tick();
      #1;
      g3[c-1] = gnt;
    end
    exp3 = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 9; i++) chk("t3_gnt_seq", RW'(g3[i]), RW'(exp3[i]));
    req = 2'b00;
    for (int c = 0; c < 6; c++) tick();

    // Zero length (128 rows) with a 3-cycle stall.
    req = 2'b01; wr = 2'b01; addr[0] = 7'd10; len[0] = 8'd0;
    nb = 0; done_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      req = 2'b00;
      enable = !(c >= 21 && c <= 23);
      wdata[0] = rnd_row();
      #1;
      if (c >= 21 && c <= 23) begin
        chk("t4_stall_beat", RW'(beat), '0);
        chk("t4_stall_wr_en", RW'(sram_wr_en), '0);
      end
      if (c == 24) chk("t4_resume_addr", RW'(sram_addr), RW'(30));
      if (beat[0]) nb++;
      if (done[0]) begin
        done_cyc = c;
        break;
      end
    end
    enable = 1'b1;
    chk("t4_nbeats", RW'(nb), RW'(128));
    chk("t4_done_cycle", RW'(done_cyc), RW'(132));
    tick();

    // Reset after the second beat of a 10-row write.
    snap = m_mem[42];
    req = 2'b01; wr = 2'b01; addr[0] = 7'd40; len[0] = 8'd10; wdata[0] = rnd_row();
    for (int c = 1; c <= 2; c++) begin
      tick();
      req = 2'b00; wdata[0] = rnd_row();
    end
    rst_n = 1'b0;
    tick();
    #1;
    chk("t5_gnt", RW'(gnt), '0);
    chk("t5_done", RW'(done), '0);
    chk("t5_wr_en", RW'(sram_wr_en), '0);
    chk("t5_beat", RW'(beat), '0);
    rst_n = 1'b1;
    tick();
    chk("t5_row42_kept", RW'(s_mem[42]), snap);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n  = ($urandom_range(0, 399) != 0);
      enable = ($urandom_range(0, 9) != 0);
      req    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      wr     = 2'($urandom_range(0, 3));
      addr[0] = 7'($urandom_range(0, 127));
      addr[1] = 7'($urandom_range(0, 127));
      len[0] = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      len[1] = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      wdata[0] = rnd_row();
      wdata[1] = rnd_row();
    end
    rst_n = 1'b1; enable = 1'b1; req = 2'b00;
    for (int c = 0; c < 300; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
